// File: rtl/seq_mult_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : seq_mult_pkg                                            |
// | Brief    : Shared types and constants for the sequential           |
// |            shift-add multiplier (state enum, default width).       |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package seq_mult_pkg;

   // Default operand width; legal range is 2..32.
   localparam int c_default_width = 8;

   // Controller states: waiting for start, iterating, result presentation.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

endpackage : seq_mult_pkg
`default_nettype wire

// File: rtl/seq_mult_operand_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : operand_reg                                             |
// | Brief    : Load-enabled operand register with asynchronous,        |
// |            active-high reset to zero.                              |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module operand_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_q;

   // Capture d on any edge where load is asserted; otherwise hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (load) begin
         r_q <= d;
      end
   end

   assign q = r_q;

endmodule : operand_reg
`default_nettype wire

// File: rtl/seq_mult.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : seq_mult                                                |
// | Brief    : Sequential shift-add multiplier. Two operand registers  |
// |            share the din bus; a start request snapshots them into  |
// |            working registers and WIDTH shift-add steps follow.     |
// |            done pulses for one cycle with the product valid.       |
// |            Optional macro SEQ_MULT_SIGNED_EN selects two's-        |
// |            complement operands (sign-magnitude internally).        |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module seq_mult
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = c_default_width
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   din,
   input  logic               load_a,
   input  logic               load_b,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   // Iteration counter must hold 0..WIDTH-1 with one bit of headroom.
   localparam int               c_cnt_w = $clog2(WIDTH) + 1;
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
   localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

   // Architectural operand registers.
   logic [WIDTH-1:0]   w_a;
   logic [WIDTH-1:0]   w_b;

   // Operand magnitudes fed into the working registers at start.
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;

   // Working registers for the in-flight multiplication.
   state_t             r_state;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [c_cnt_w-1:0] r_cnt;

   // Registered outputs.
   logic               r_busy;
   logic               r_done;
   logic [2*WIDTH-1:0] r_product;

   // One shift-add step: accumulator plus the multiplicand when the
   // current multiplier LSB is set.
   logic [2*WIDTH-1:0] w_addend;
   logic [2*WIDTH-1:0] w_sum;
   logic [2*WIDTH-1:0] w_result;

   operand_reg #(
      .WIDTH (WIDTH)
   ) u_reg_a (
      .clk  (clk),
      .rst  (rst),
      .load (load_a),
      .d    (din),
      .q    (w_a)
   );

   operand_reg #(
      .WIDTH (WIDTH)
   ) u_reg_b (
      .clk  (clk),
      .rst  (rst),
      .load (load_b),
      .d    (din),
      .q    (w_b)
   );

   assign w_addend = r_mplier[0] ? r_mcand : '0;
   assign w_sum    = r_acc + w_addend;

`ifdef SEQ_MULT_SIGNED_EN
   // Result sign captured at start: operands of differing sign.
   logic r_neg;

   // Two's-complement magnitudes. The most negative value maps onto
   // itself, which is the correct unsigned magnitude 2**(WIDTH-1).
   assign w_mag_a = w_a[WIDTH-1] ? ((~w_a) + {{(WIDTH-1){1'b0}}, 1'b1}) : w_a;
   assign w_mag_b = w_b[WIDTH-1] ? ((~w_b) + {{(WIDTH-1){1'b0}}, 1'b1}) : w_b;

   // Apply the result sign to the final magnitude on the last step.
   assign w_result = r_neg ? ((~w_sum) + {{(2*WIDTH-1){1'b0}}, 1'b1}) : w_sum;

   // Latch the result sign alongside the operand snapshot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_neg <= 1'b0;
      end else if ((r_state == IDLE) && start) begin
         r_neg <= w_a[WIDTH-1] ^ w_b[WIDTH-1];
      end
   end
`else
   assign w_mag_a  = w_a;
   assign w_mag_b  = w_b;
   assign w_result = w_sum;
`endif

   // Controller and datapath: snapshot on start, WIDTH shift-add steps,
   // then a single FIN cycle carrying the done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_acc     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_product <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               // Operand registers still hold pre-edge values here, so a
               // load in the same cycle as start does not leak in.
               if (start) begin
                  r_acc    <= '0;
                  r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                  r_mplier <= w_mag_b;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= RUN;
               end
            end
            RUN: begin
               r_acc    <= w_sum;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + c_one;
               // Final step writes straight to product so no partial sum
               // is ever visible on the output.
               if (r_cnt == c_last) begin
                  r_product <= w_result;
                  r_done    <= 1'b1;
                  r_state   <= FIN;
               end
            end
            FIN: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign product = r_product;

endmodule : seq_mult
`default_nettype wire

// File: tb/tb_seq_mult.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_seq_mult                                             |
// | Brief    : Self-checking bench for seq_mult at WIDTH=8 and 16,     |
// |            with a transaction-level reference model and literal    |
// |            expectations. Honours SEQ_MULT_SIGNED_EN.               |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_seq_mult;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [7:0]  din8  = '0;
   logic        la8   = 1'b0;
   logic        lb8   = 1'b0;
   logic        st8   = 1'b0;
   logic        busy8;
   logic        done8;
   logic [15:0] prod8;

   logic [15:0] din16 = '0;
   logic        la16  = 1'b0;
   logic        lb16  = 1'b0;
   logic        st16  = 1'b0;
   logic        busy16;
   logic        done16;
   logic [31:0] prod16;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   seq_mult #(.WIDTH(8)) dut8 (
      .clk     (clk),
      .rst     (rst),
      .din     (din8),
      .load_a  (la8),
      .load_b  (lb8),
      .start   (st8),
      .busy    (busy8),
      .done    (done8),
      .product (prod8)
   );

   seq_mult #(.WIDTH(16)) dut16 (
      .clk     (clk),
      .rst     (rst),
      .din     (din16),
      .load_a  (la16),
      .load_b  (lb16),
      .start   (st16),
      .busy    (busy16),
      .done    (done16),
      .product (prod16)
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      int          rem;   // busy cycles left; 0 when idle
      logic [31:0] pend;
      logic [31:0] prod;
      logic        done;
   } mdl_t;

   mdl_t m8;
   mdl_t m16;

   function automatic logic [31:0] ref_mul(int w, logic [31:0] a, logic [31:0] b);
      longint sa;
      longint sb;
      longint p;
      longint mask;
      mask = (64'sd1 <<< (2 * w)) - 64'sd1;
`ifdef SEQ_MULT_SIGNED_EN
      sa = a[w-1] ? (longint'(a) - (64'sd1 <<< w)) : longint'(a);
      sb = b[w-1] ? (longint'(b) - (64'sd1 <<< w)) : longint'(b);
`else
      sa = longint'(a);
      sb = longint'(b);
`endif
      p = (sa * sb) & mask;
      return p[31:0];
   endfunction

   function automatic mdl_t mdl_reset();
      mdl_t n;
      n.a = '0; n.b = '0; n.rem = 0; n.pend = '0; n.prod = '0; n.done = 1'b0;
      return n;
   endfunction

   function automatic mdl_t mdl_step(mdl_t m, int w, logic [31:0] d,
                                     logic la, logic lb, logic st);
      mdl_t n;
      n = m;
      n.done = 1'b0;
      if (m.rem > 0) begin
         n.rem = m.rem - 1;
         if (n.rem == 1) begin
            n.done = 1'b1;
            n.prod = m.pend;
         end
      end else if (st) begin
         n.pend = ref_mul(w, m.a, m.b);
         n.rem  = w + 1;
      end
      if (la) n.a = d;
      if (lb) n.b = d;
      return n;
   endfunction

   // Advance the model with the inputs seen at each rising edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m8  = mdl_reset();
         m16 = mdl_reset();
      end else begin
         m8  = mdl_step(m8,  8,  {24'd0, din8},  la8,  lb8,  st8);
         m16 = mdl_step(m16, 16, {16'd0, din16}, la16, lb16, st16);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("busy8",  {31'd0, busy8},  {31'd0, m8.rem > 0});
      chk("done8",  {31'd0, done8},  {31'd0, m8.done});
      chk("prod8",  {16'd0, prod8},  m8.prod);
      chk("busy16", {31'd0, busy16}, {31'd0, m16.rem > 0});
      chk("done16", {31'd0, done16}, {31'd0, m16.done});
      chk("prod16", prod16,          m16.prod);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(int ch, logic [31:0] d, logic la, logic lb, logic st);
      din8 = '0; la8 = 1'b0; lb8 = 1'b0; st8 = 1'b0;
      din16 = '0; la16 = 1'b0; lb16 = 1'b0; st16 = 1'b0;
      if (ch == 0) begin
         din8 = d[7:0]; la8 = la; lb8 = lb; st8 = st;
      end else begin
         din16 = d[15:0]; la16 = la; lb16 = lb; st16 = st;
      end
   endtask

   function automatic logic done_of(int ch);
      return (ch == 0) ? done8 : done16;
   endfunction

   function automatic logic [31:0] prod_of(int ch);
      return (ch == 0) ? {16'd0, prod8} : prod16;
   endfunction

   // Wait (bounded) for done, k counts cycles since the start cycle N.
   task automatic wait_done(int ch, int k0, logic [31:0] exp, int lat, string nm);
      int k;
      k = k0;
      while (!done_of(ch) && k < 60) begin
         tick();
         k++;
      end
      chk({nm, "_lat"}, k, lat);
      chk({nm, "_prod"}, prod_of(ch), exp);
      tick();
   endtask

   task automatic start_op(int ch, logic [31:0] exp, int lat, string nm);
      drive(ch, 0, 1'b0, 1'b0, 1'b1);
      tick();
      drive(ch, 0, 1'b0, 1'b0, 1'b0);
      wait_done(ch, 1, exp, lat, nm);
   endtask

   task automatic run_op(int ch, logic [31:0] a, logic [31:0] b,
                         logic [31:0] exp, int lat, string nm);
      drive(ch, a, 1'b1, 1'b0, 1'b0);
      tick();
      drive(ch, b, 1'b0, 1'b1, 1'b0);
      tick();
      start_op(ch, exp, lat, nm);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      drive(0, 0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_prod8", {16'd0, prod8}, 32'h0);
      chk("rst_busy8", {31'd0, busy8}, 32'h0);
      chk("rst_prod16", prod16, 32'h0);

`ifdef SEQ_MULT_SIGNED_EN
      run_op(0, 32'hFF, 32'hFF, 32'h0001, 9, "ffxff");
`else
      run_op(0, 32'hFF, 32'hFF, 32'hFE01, 9, "ffxff");
`endif
      run_op(0, 32'h00, 32'hA5, 32'h0000, 9, "zero");
      run_op(0, 32'h0C, 32'h0D, 32'h009C, 9, "0cx0d");

      // Both load strobes together: A = B = 9.
      drive(0, 32'h09, 1'b1, 1'b1, 1'b0);
      tick();
      start_op(0, 32'h0051, 9, "loadboth");

      // Start and load_a while busy: ignored start, A changes for later.
      drive(0, 32'h12, 1'b1, 1'b0, 1'b0);
      tick();
      drive(0, 32'h34, 1'b0, 1'b1, 1'b0);
      tick();
      drive(0, 0, 1'b0, 1'b0, 1'b1);
      tick();                             // cycle N+1
      drive(0, 0, 1'b0, 1'b0, 1'b0);
      tick();                             // cycle N+2
      tick();                             // cycle N+3
      drive(0, 32'h77, 1'b1, 1'b0, 1'b1);
      tick();                             // cycle N+4
      drive(0, 0, 1'b0, 1'b0, 1'b0);
      wait_done(0, 4, 32'h03A8, 9, "overlap");
      start_op(0, 32'h182C, 9, "newa");   // 0x77 * 0x34

      // Reset in the middle of a run.
      drive(0, 32'h12, 1'b1, 1'b0, 1'b0);
      tick();
      drive(0, 32'h34, 1'b0, 1'b1, 1'b0);
      tick();
      drive(0, 0, 1'b0, 1'b0, 1'b1);
      tick();                             // cycle N+1
      drive(0, 0, 1'b0, 1'b0, 1'b0);
      repeat (3) tick();                  // cycle N+4
      rst = 1'b1;
      #1;
      chk("midrst_prod", {16'd0, prod8}, 32'h0);
      chk("midrst_busy", {31'd0, busy8}, 32'h0);
      chk("midrst_done", {31'd0, done8}, 32'h0);
      tick();
      rst = 1'b0;
      tick();
      run_op(0, 32'h03, 32'h05, 32'h000F, 9, "3x5");

`ifdef SEQ_MULT_SIGNED_EN
      run_op(0, 32'hFD, 32'h05, 32'hFFF1, 9, "neg3x5");
      run_op(0, 32'h80, 32'h80, 32'h4000, 9, "minxmin");
      run_op(1, 32'hFFFF, 32'hFFFF, 32'h00000001, 17, "w16");
      run_op(1, 32'h8000, 32'h0003, 32'hFFFE8000, 17, "w16neg");
`else
      run_op(1, 32'hFFFF, 32'hFFFF, 32'hFFFE0001, 17, "w16");
      run_op(1, 32'h1234, 32'h0100, 32'h00123400, 17, "w16b");
`endif

      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule : tb_seq_mult
`default_nettype wire

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 din  input  WIDTH  operand data bus shared by both operand registers.
REQ-005 load_a  input  1  when high at a clk edge, operand register A captures din.
REQ-006 load_b  input  1  when high at a clk edge, operand register B captures din.
REQ-007 start  input  1  single-cycle request to multiply the current A and B.
REQ-008 busy  output  1  high while a multiplication is in progress.
REQ-009 done  output  1  one-cycle pulse when product becomes valid.
REQ-010 product  output  2*WIDTH  result of the last completed multiplication.

Function
REQ-011 States SHALL be IDLE, RUN and FIN. IDLE goes to RUN on start. RUN goes to FIN after WIDTH iterations. FIN goes to IDLE unconditionally.
REQ-012 On entry to RUN, A and B SHALL be snapshotted into working registers. Later load_a/load_b SHALL update A/B only and SHALL NOT affect the in-flight operation.
REQ-013 RUN SHALL perform one shift-add step per cycle (test multiplier LSB, conditionally add multiplicand, shift), for exactly WIDTH cycles.
REQ-014 Latency: start sampled high in cycle N; done SHALL be high in cycle N+WIDTH+1, with product valid in that same cycle.
REQ-015 busy SHALL be high in RUN and FIN and low in IDLE.
REQ-016 start asserted while busy SHALL be ignored, with no queuing.
REQ-017 start and load_a/load_b in the same cycle: the multiplication SHALL use the pre-edge A/B values.
REQ-018 product SHALL hold its value from FIN until the next FIN. Intermediate sums SHALL NOT appear on product.
REQ-019 Arithmetic SHALL be unsigned and exact: product = A*B with no overflow, since 2*WIDTH bits covers the full range.
REQ-020 load_a and load_b high together SHALL load both registers with din.

Reset
REQ-021 rst SHALL force IDLE and clear A, B, the working registers and product to 0, with busy=0 and done=0, regardless of clk.
REQ-022 rst asserted mid-RUN SHALL abandon the operation, with no done pulse. The first start after rst deasserts SHALL behave per REQ-014.

Configuration
REQ-023 Macro SEQ_MULT_SIGNED_EN defined: A and B SHALL be treated as two's-complement. The block multiplies magnitudes and negates the result if the operand signs differ, producing a signed 2*WIDTH product. Latency SHALL be identical to REQ-014.
REQ-024 Macro SEQ_MULT_SIGNED_EN undefined: unsigned behaviour per REQ-019, with no sign logic present.

Structure
REQ-025 Package seq_mult_pkg SHALL hold the state enum (IDLE/RUN/FIN) and the default WIDTH constant.
REQ-026 Operand registers SHALL be instances of sub-module operand_reg: WIDTH-bit, load-enabled, async active-high reset to 0.
REQ-027 The FSM, iteration counter ($clog2(WIDTH)+1 bits) and datapath SHALL live in seq_mult.

Verification
REQ-028 WIDTH=8. Load A=0xFF and B=0xFF, then pulse start. Required: busy for 9 cycles, done exactly 9 cycles after start, product=0xFE01.
REQ-029 WIDTH=8. Load A=0x00 and B=0xA5, then start. Required: product=0x0000 and done at N+9. Then A=0x0C, B=0x0D gives product=0x009C.
REQ-030 Start the 0x12*0x34 operation; at cycle N+3, pulse start again and load A=0x77. Required: a single done, product=0x03A8, and A=0x77 afterwards.
REQ-031 Assert rst at cycle N+4 of a run. Required: immediate product=0, busy=0, no done. Then 0x03*0x05 gives product=0x000F.
REQ-032 SEQ_MULT_SIGNED_EN defined, WIDTH=8. A=0xFD (-3) and B=0x05 give 0xFFF1. A=0x80 and B=0x80 give 0x4000.
REQ-033 WIDTH=16. 0xFFFF*0xFFFF SHALL give 0xFFFE0001 with done at N+17.
